// File: rtl/q_pkg.sv
// Shared constants and FSM encoding for the Qmax refresh block.
package q_pkg;

    localparam int unsigned STATE_WIDTH  = 6;
    localparam int unsigned ACTION_WIDTH = 2;
    // Must satisfy 1 <= NUM_ACTIONS <= 2**ACTION_WIDTH.
    localparam int unsigned NUM_ACTIONS  = 4;
    localparam int unsigned DATA_WIDTH   = 8;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StWrite = 2'd3;

endpackage

// File: rtl/qmax_argmax_acc.sv
// Running signed maximum / argmax register. The next-state values are also
// exported so the caller can capture the final result on the same edge that
// absorbs the last sample.
module qmax_argmax_acc import q_pkg::*; #(
    parameter int unsigned DATA_W   = DATA_WIDTH,
    parameter int unsigned ACTION_W = ACTION_WIDTH
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_init,
    input  logic                i_en,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [ACTION_W-1:0] i_action,
    output logic [DATA_W-1:0]   o_max_nxt,
    output logic [ACTION_W-1:0] o_arg_nxt
);

    logic [DATA_W-1:0]   max_q;
    logic [ACTION_W-1:0] arg_q;
    logic                take;

    // Replace on init or strictly greater sample; ties keep the lower action.
    always_comb begin
        take      = i_init || ($signed(i_data) > $signed(max_q));
        o_max_nxt = max_q;
        o_arg_nxt = arg_q;
        if (i_en && take) begin
            o_max_nxt = i_data;
            o_arg_nxt = i_action;
        end
    end

    // Hold the running max/argmax between samples.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            max_q <= '0;
            arg_q <= '0;
        end else begin
            max_q <= o_max_nxt;
            arg_q <= o_arg_nxt;
        end
    end

endmodule

// File: rtl/qmax_updater.sv
// Qmax refresh initiator: sweeps Q(s,*) one read per cycle, tracks the signed
// max/argmax, then writes the result into the Qmax table with a done pulse.
module qmax_updater import q_pkg::*; (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_req_valid,
    input  logic [STATE_WIDTH-1:0]              i_req_state,
    output logic                                o_req_ready,
    output logic [STATE_WIDTH+ACTION_WIDTH-1:0] o_q_addr,
    output logic                                o_q_read_en,
    input  logic [DATA_WIDTH-1:0]               i_q_data,
    output logic [STATE_WIDTH-1:0]              o_qmax_addr_w,
    output logic                                o_qmax_write_en,
    output logic [DATA_WIDTH-1:0]               o_qmax_data,
    output logic [ACTION_WIDTH-1:0]             o_max_action,
    output logic                                o_done,
    output logic                                o_busy
);

    // Read counter is one bit wider so it can reach NUM_ACTIONS without wrapping.
    localparam logic [ACTION_WIDTH:0] RdLast = (ACTION_WIDTH+1)'(NUM_ACTIONS);
    localparam logic [ACTION_WIDTH:0] RdOne  = (ACTION_WIDTH+1)'(1);

    logic [1:0]              fsm_q;
    logic [STATE_WIDTH-1:0]  state_q;
    logic [ACTION_WIDTH:0]   rd_cnt_q;
    logic                    rd_pend_q;  // read data valid this cycle
    logic [ACTION_WIDTH-1:0] rd_act_q;   // action index of that data
    logic [DATA_WIDTH-1:0]   max_nxt;
    logic [ACTION_WIDTH-1:0] arg_nxt;
    logic                    acc_init;

    assign acc_init = rd_pend_q && (rd_act_q == '0);

    qmax_argmax_acc #(
        .DATA_W   (DATA_WIDTH),
        .ACTION_W (ACTION_WIDTH)
    ) u_acc (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_init    (acc_init),
        .i_en      (rd_pend_q),
        .i_data    (i_q_data),
        .i_action  (rd_act_q),
        .o_max_nxt (max_nxt),
        .o_arg_nxt (arg_nxt)
    );

    // FSM, read address generation and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fsm_q           <= StIdle;
            state_q         <= '0;
            rd_cnt_q        <= '0;
            rd_pend_q       <= 1'b0;
            rd_act_q        <= '0;
            o_req_ready     <= 1'b1;
            o_busy          <= 1'b0;
            o_q_addr        <= '0;
            o_q_read_en     <= 1'b0;
            o_qmax_addr_w   <= '0;
            o_qmax_write_en <= 1'b0;
            o_qmax_data     <= '0;
            o_max_action    <= '0;
            o_done          <= 1'b0;
        end else begin
            o_qmax_write_en <= 1'b0;
            o_done          <= 1'b0;
            // BRAM returns data one cycle after the enable; track which action it is.
            rd_pend_q       <= o_q_read_en;
            rd_act_q        <= o_q_addr[ACTION_WIDTH-1:0];

            unique case (fsm_q)
                StIdle: begin
                    if (i_req_valid) begin
                        state_q     <= i_req_state;
                        o_q_addr    <= {i_req_state, {ACTION_WIDTH{1'b0}}};
                        o_q_read_en <= 1'b1;
                        rd_cnt_q    <= RdOne;
                        o_req_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        fsm_q       <= StRead;
                    end
                end
                StRead: begin
                    if (rd_cnt_q == RdLast) begin
                        o_q_read_en <= 1'b0;
                        fsm_q       <= StDrain;
                    end else begin
                        o_q_addr <= {state_q, rd_cnt_q[ACTION_WIDTH-1:0]};
                        rd_cnt_q <= rd_cnt_q + RdOne;
                    end
                end
                StDrain: begin
                    // Last sample is absorbed on this edge, so take the accumulator's next value.
                    o_qmax_write_en <= 1'b1;
                    o_done          <= 1'b1;
                    o_qmax_addr_w   <= state_q;
                    o_qmax_data     <= max_nxt;
                    o_max_action    <= arg_nxt;
                    fsm_q           <= StWrite;
                end
                StWrite: begin
                    o_req_ready <= 1'b1;
                    o_busy      <= 1'b0;
                    fsm_q       <= StIdle;
                end
                default: begin
                    fsm_q <= StIdle;
                end
            endcase
        end
    end

endmodule
